// File: rtl/shift_add_mult_seq.sv
// -----------------------------------------------------------------------------
// shift_add_mult_seq
//
// Sequential shift-and-add multiplier. One partial-product add/shift per clock.
// Operands are unsigned or two's-complement, selected per operation. The core
// always multiplies magnitudes. The sign is applied once, when the result is
// written to the product register.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request a multiply; accepted only when not busy (IDLE or DONE)
//   signed_mode  0 = unsigned operands, 1 = two's-complement operands
//   a            multiplicand (WIDTH bits), sampled with start
//   b            multiplier   (WIDTH bits), sampled with start
//   busy         high while iterating (CALC)
//   done         one-cycle pulse; product valid from this cycle on
//   product      2*WIDTH-bit result register; holds until the next DONE
// -----------------------------------------------------------------------------
module shift_add_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW    = 2 * WIDTH;
    localparam int SW    = PW + 1;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   mag_a, mag_a_next;
    logic               sgn, sgn_next;
    logic [SW-1:0]      acc, acc_next, acc_add;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [PW-1:0]      product_next;

    // Magnitude of an operand. In signed mode the most negative value
    // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits as an unsigned number.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sm);
        if (sm && x[WIDTH-1])
            return -x;
        else
            return x;
    endfunction

    // Re-apply the result sign as a two's complement over the full product width.
    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] p,
                                                 input logic          neg);
        if (neg)
            return -p;
        else
            return p;
    endfunction

    always_comb begin
        state_next   = state;
        mag_a_next   = mag_a;
        sgn_next     = sgn;
        acc_next     = acc;
        cnt_next     = cnt;
        product_next = product;
        acc_add      = acc;

        case (state)
            IDLE, DONE: begin
                // DONE accepts a new start exactly like IDLE (back-to-back).
                if (start) begin
                    state_next = CALC;
                    mag_a_next = magnitude(a, signed_mode);
                    sgn_next   = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_next   = {{(WIDTH + 1){1'b0}}, magnitude(b, signed_mode)};
                    cnt_next   = '0;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                // The add happens at full SW width so its carry lands in the
                // extra MSB and survives the following shift.
                if (acc[0])
                    acc_add = acc + {1'b0, mag_a, {WIDTH{1'b0}}};
                acc_next = acc_add >> 1;
                cnt_next = cnt + CNT_W'(1);
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_next   = DONE;
                    product_next = apply_sign(acc_next[PW-1:0], sgn);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mag_a   <= '0;
            sgn     <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            state   <= state_next;
            mag_a   <= mag_a_next;
            sgn     <= sgn_next;
            acc     <= acc_next;
            cnt     <= cnt_next;
            product <= product_next;
        end
    end

    // Decoded directly from the state register, so there is no path from
    // any input to these outputs.
    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mult_seq
//
// Directed bench for shift_add_mult_seq. One instance is built at WIDTH=4 and
// one at WIDTH=8. Both share the clock and reset. Expected products are
// hand-computed constants, except in the WIDTH=4 sweep, which uses a*b.
// -----------------------------------------------------------------------------
module tb_shift_add_mult_seq;

    logic       clk;
    logic       rst_n;

    logic       start4, sm4, busy4, done4;
    logic [3:0] a4, b4;
    logic [7:0] product4;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int n_tests = 0;
    int n_fail  = 0;

    shift_add_mult_seq #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .signed_mode(sm4),
        .a          (a4),
        .b          (b4),
        .busy       (busy4),
        .done       (done4),
        .product    (product4)
    );

    shift_add_mult_seq #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .signed_mode(sm8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .product    (product8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one WIDTH=4 multiply and check latency, busy length, result and done pulse.
    task automatic mul4(input logic [3:0] ta, input logic [3:0] tbv, input logic sm,
                        input logic [7:0] exp, input string tag);
        int n;
        int bc;
        a4 = ta; b4 = tbv; sm4 = sm; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 0; bc = 0;
        while (!done4 && n < 20) begin
            if (busy4) bc++;
            tick();
            n++;
        end
        check_val({tag, " latency"}, n, 4);
        check_val({tag, " busy_cycles"}, bc, 4);
        check_val({tag, " busy_at_done"}, busy4, 0);
        check_val({tag, " product"}, product4, exp);
        tick();
        check_val({tag, " done_pulse"}, done4, 0);
    endtask

    // Issue one WIDTH=8 multiply and check latency, busy length and result.
    task automatic mul8(input logic [7:0] ta, input logic [7:0] tbv, input logic sm,
                        input logic [15:0] exp, input string tag);
        int n;
        int bc;
        a8 = ta; b8 = tbv; sm8 = sm; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0; bc = 0;
        while (!done8 && n < 30) begin
            if (busy8) bc++;
            tick();
            n++;
        end
        check_val({tag, " latency"}, n, 8);
        check_val({tag, " busy_cycles"}, bc, 8);
        check_val({tag, " product"}, product8, exp);
        tick();
        check_val({tag, " done_pulse"}, done8, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int m;
        int dcount;
        int hold_bad;
        logic signed [3:0] sa;
        logic signed [3:0] sb;
        int p;
        logic [7:0] e4;

        rst_n = 1'b0;
        start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
        start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
        #12;
        check_val("rst busy8", busy8, 0);
        check_val("rst done8", done8, 0);
        check_val("rst product8", product8, 0);
        check_val("rst product4", product4, 0);
        rst_n = 1'b1;
        tick();

        // Directed unsigned, WIDTH=4
        mul4(4'd13, 4'd11, 1'b0, 8'd143, "u4 13x11");
        mul4(4'd15, 4'd15, 1'b0, 8'd225, "u4 15x15");
        mul4(4'd0,  4'd9,  1'b0, 8'd0,   "u4 0x9");

        // Directed signed, WIDTH=8
        mul8(8'hFD, 8'h07, 1'b1, 16'hFFEB, "s8 -3x7");
        mul8(8'h80, 8'h80, 1'b1, 16'h4000, "s8 -128x-128");
        mul8(8'h80, 8'h7F, 1'b1, 16'hC080, "s8 -128x127");
        mul8(8'h7F, 8'h7F, 1'b1, 16'h3F01, "s8 127x127");
        mul8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s8 -1x-1");

        // Reset in the 3rd CALC cycle
        a8 = 8'd200; b8 = 8'd100; sm8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        check_val("midrst busy_before", busy8, 1);
        rst_n = 1'b0;
        #1;
        check_val("midrst busy", busy8, 0);
        check_val("midrst done", done8, 0);
        check_val("midrst product", product8, 0);
        #1;
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done8 || busy8) dcount++;
        end
        check_val("midrst no_activity", dcount, 0);
        mul8(8'd3, 8'd5, 1'b0, 16'd15, "after_rst 3x5");

        // start while busy is ignored; operand changes during CALC have no effect
        a8 = 8'd10; b8 = 8'd20; sm8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'd99; b8 = 8'd77; sm8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF;
        n = 1;
        while (!done8 && n < 30) begin
            tick();
            n++;
        end
        check_val("hs latency", n, 8);
        check_val("hs product", product8, 16'd200);
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8) dcount++;
        end
        check_val("hs extra_done", dcount, 0);

        // Back-to-back with start held high
        a8 = 8'd25; b8 = 8'd4; sm8 = 1'b0; start8 = 1'b1;
        tick();
        a8 = 8'd255; b8 = 8'd255;
        n = 0;
        while (!done8 && n < 30) begin
            tick();
            n++;
        end
        check_val("b2b first_latency", n, 8);
        check_val("b2b first_product", product8, 16'd100);
        tick();
        m = 1;
        hold_bad = 0;
        while (!done8 && m < 30) begin
            if (product8 !== 16'd100) hold_bad++;
            tick();
            m++;
        end
        start8 = 1'b0;
        check_val("b2b interval", m, 9);
        check_val("b2b hold", hold_bad, 0);
        check_val("b2b second_product", product8, 16'd65025);
        tick();
        tick();

        // Exhaustive sweep, WIDTH=4, both modes
        for (int md = 0; md < 2; md++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    if (md == 0) begin
                        p = ia * ib;
                    end else begin
                        sa = 4'(ia);
                        sb = 4'(ib);
                        p = sa * sb;
                    end
                    e4 = p[7:0];
                    mul4(4'(ia), 4'(ib), md[0], e4, $sformatf("sweep m%0d %0dx%0d", md, ia, ib));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
